// File: rtl/layer_mac_sequencer_if.sv
// Handshake and datapath-control bundle between the layer sequencer and its
// environment (network controller, MAC, weight ROM, activation, next layer).
interface layer_mac_sequencer_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 4
);
  localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int OUT_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WADDR_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

  logic               start;
  logic               busy;
  logic               done;
  logic               mac_clr;
  logic               mac_en;
  logic [IDX_W-1:0]   in_idx;
  logic [WADDR_W-1:0] w_addr;
  logic               mac_ack;
  logic               act_en;
  logic               out_valid;
  logic [OUT_W-1:0]   out_idx;
  logic               out_ready;

  modport master (
    input  start, mac_ack, out_ready,
    output busy, done, mac_clr, mac_en, in_idx, w_addr, act_en, out_valid, out_idx
  );

  modport slave (
    output start, mac_ack, out_ready,
    input  busy, done, mac_clr, mac_en, in_idx, w_addr, act_en, out_valid, out_idx
  );
endinterface

// File: rtl/layer_mac_sequencer.sv
// Sequencer for one fully-connected layer sharing a single MAC: per neuron it
// clears, runs N_IN acked MAC steps, fires activation, then hands the index on.
module layer_mac_sequencer #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  layer_mac_sequencer_if.master  bus
);
  localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int OUT_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WADDR_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ISSUE,
    S_WAIT_ACK,
    S_ACT,
    S_EMIT,
    S_DONE
  } state_e;

  state_e           state, state_nxt;
  logic [IDX_W-1:0] k, k_nxt;
  logic [OUT_W-1:0] n, n_nxt;
  logic             k_last, n_last;

  assign k_last = (k == IDX_W'(N_IN - 1));
  assign n_last = (n == OUT_W'(N_OUT - 1));

  // Inputs are only looked at in the state that owns them, so stray acks,
  // readies and starts fall through to the hold defaults.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise paths
    // that leave it unassigned would infer latches.
    state_nxt = state;
    k_nxt     = k;
    n_nxt     = n;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          n_nxt     = '0;
          state_nxt = S_CLR;
        end
      end
      S_CLR: begin
        k_nxt     = '0;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (bus.mac_ack) begin
          if (k_last) begin
            state_nxt = S_ACT;
          end else begin
            k_nxt     = k + 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ACT: state_nxt = S_EMIT;
      S_EMIT: begin
        if (bus.out_ready) begin
          if (n_last) begin
            state_nxt = S_DONE;
          end else begin
            n_nxt     = n + 1'b1;
            state_nxt = S_CLR;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state/counters, so they line up with
  // the state they describe and never see an input combinationally.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state         <= S_IDLE;
      k             <= '0;
      n             <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mac_clr   <= 1'b0;
      bus.mac_en    <= 1'b0;
      bus.act_en    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.in_idx    <= '0;
      bus.w_addr    <= '0;
      bus.out_idx   <= '0;
    end else begin
      state         <= state_nxt;
      k             <= k_nxt;
      n             <= n_nxt;
      bus.busy      <= (state_nxt != S_IDLE);
      bus.done      <= (state_nxt == S_DONE);
      bus.mac_clr   <= (state_nxt == S_CLR);
      bus.mac_en    <= (state_nxt == S_ISSUE);
      bus.act_en    <= (state_nxt == S_ACT);
      bus.out_valid <= (state_nxt == S_EMIT);
      bus.in_idx    <= k_nxt;
      bus.w_addr    <= WADDR_W'(n_nxt) * WADDR_W'(N_IN) + WADDR_W'(k_nxt);
      bus.out_idx   <= n_nxt;
    end
  end
endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Scoreboard bench for layer_mac_sequencer: directed passes push their expected
// strobe/handshake events with cycle stamps; a negedge monitor pops and compares.
module tb_layer_mac_sequencer;
  localparam int N_IN    = 3;
  localparam int N_OUT   = 4;
  localparam int PASS_CY = 37;

  typedef enum int { EV_CLR, EV_EN, EV_ACT, EV_OUT, EV_DONE } ev_e;
  typedef struct {
    ev_e kind;
    int  a;
    int  b;
    int  at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  int ack_mode   = 0;   // 0 respond to mac_en, 1 toggle, 2 hold high
  int slow_en    = -1;  // index of the mac_en (within a pass) that gets a slow ack
  int slow_delay = 1;

  layer_mac_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) m ();

  layer_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] out_word();
    return 32'({m.busy, m.done, m.mac_clr, m.mac_en, m.act_en, m.out_valid,
                m.in_idx, m.w_addr, m.out_idx});
  endfunction

  task automatic push_ev(input ev_e kind, input int a, input int b, input int at);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Expected event schedule for one pass whose CLR lands in cycle s.
  // slow_i: mac_en index acked slow_x cycles late; hold_n: neuron whose
  // out_valid is held for hold_x extra cycles.
  task automatic push_pass(input int s, input int slow_i, input int slow_x,
                           input int hold_n, input int hold_x);
    int t;
    int vlen;
    t = s;
    for (int n = 0; n < N_OUT; n++) begin
      push_ev(EV_CLR, n, 0, t);
      t++;
      for (int k = 0; k < N_IN; k++) begin
        push_ev(EV_EN, n * N_IN + k, k, t);
        t += 2;
        if (n * N_IN + k == slow_i) t += slow_x;
      end
      push_ev(EV_ACT, n, 0, t);
      t++;
      vlen = 1 + ((n == hold_n) ? hold_x : 0);
      t += vlen - 1;
      push_ev(EV_OUT, n, vlen, t);
      t++;
    end
    push_ev(EV_DONE, 0, 0, t);
  endtask

  task automatic observe(input ev_e kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_%s: got event a=%0d at cycle %0d, required none",
               kind.name(), a, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check($sformatf("%s_cycle", e.kind.name()), cyc, e.at);
      if (e.kind != EV_DONE) check($sformatf("%s_idx", e.kind.name()), a, e.a);
      if (e.kind == EV_EN || e.kind == EV_OUT)
        check($sformatf("%s_aux", e.kind.name()), b, e.b);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int vrun = 0;
  int vidx = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m.out_valid) begin
        if (vrun == 0) vidx = int'(m.out_idx);
        else check("out_idx_hold", m.out_idx, vidx);
        vrun++;
      end
      if (m.mac_clr) observe(EV_CLR, int'(m.out_idx), 0);
      if (m.mac_en)  observe(EV_EN, int'(m.w_addr), int'(m.in_idx));
      if (m.act_en)  observe(EV_ACT, int'(m.out_idx), 0);
      if (m.out_valid && m.out_ready) begin
        observe(EV_OUT, int'(m.out_idx), vrun);
        vrun = 0;
      end
      if (m.done) observe(EV_DONE, 0, 0);
      if (!m.out_valid) vrun = 0;
    end else begin
      vrun = 0;
    end
  end

  // MAC model: acks one cycle after mac_en, or slow_delay cycles for slow_en.
  int ack_cnt = 0;
  int en_seen = 0;
  int held_w  = 0;
  initial m.mac_ack = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (!m.busy) en_seen = 0;
    case (ack_mode)
      1: begin ack_cnt = 0; m.mac_ack = ~m.mac_ack; end
      2: begin ack_cnt = 0; m.mac_ack = 1'b1; end
      default: begin
        if (rst) begin
          ack_cnt   = 0;
          m.mac_ack = 1'b0;
        end else if (m.mac_en) begin
          ack_cnt   = (en_seen == slow_en) ? slow_delay : 1;
          held_w    = int'(m.w_addr);
          en_seen++;
          m.mac_ack = 1'b0;
        end else if (ack_cnt > 0) begin
          check("w_addr_stable", m.w_addr, held_w);
          ack_cnt--;
          m.mac_ack = (ack_cnt == 0);
        end else begin
          m.mac_ack = 1'b0;
        end
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_pass(input int si, input int sx, input int hn, input int hx,
                            output int s);
    s = cyc + 1;
    push_pass(s, si, sx, hn, hx);
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (m.done) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) fail("done_timeout");
  endtask

  task automatic finish_pass(input string name, input int s, input int lat);
    int at;
    wait_done(200, at);
    // Start sampled at edge t puts CLR in the cycle starting at t; done occupies
    // the cycle ending at edge t+lat.
    if (at >= 0) check({name, "_latency"}, at - s + 1, lat);
    tick();
    check({name, "_idle_after"}, m.busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int s2;
    int at;
    bit found;
    m.start     = 1'b0;
    m.out_ready = 1'b1;

    // Reset, then idle with ack/ready toggling.
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", out_word(), 0);
    rst = 1'b0;
    ack_mode = 1;
    for (int i = 0; i < 6; i++) begin
      m.out_ready = ~m.out_ready;
      tick();
      check("idle_outputs", out_word(), 0);
    end
    ack_mode    = 0;
    m.out_ready = 1'b1;
    tick();

    // Nominal pass.
    start_pass(-1, 0, -1, 0, s);
    finish_pass("nominal", s, PASS_CY);

    // Slow ack on neuron 2, step 1 (w_addr 7): 4 extra cycles.
    slow_en    = 7;
    slow_delay = 5;
    tick();
    start_pass(7, 4, -1, 0, s);
    finish_pass("slow_ack", s, PASS_CY + 4);
    slow_en = -1;

    // Downstream stall: neuron 1 held for 3 extra cycles.
    start_pass(-1, 0, 1, 3, s);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m.act_en && m.out_idx == 1) found = 1;
      else tick();
    end
    if (!found) fail("act_n1_timeout");
    m.out_ready = 1'b0;
    repeat (4) tick();
    m.out_ready = 1'b1;
    finish_pass("ready_stall", s, PASS_CY + 3);

    // start mid-pass and in DONE is ignored; start in the next IDLE is taken.
    start_pass(-1, 0, -1, 0, s);
    repeat (10) tick();
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    wait_done(200, at);
    if (at >= 0) check("first_latency", at - s + 1, PASS_CY);
    s2 = cyc + 2;
    push_pass(s2, -1, 0, -1, 0);
    m.start = 1'b1;
    tick();
    check("idle_gap", m.busy, 1'b0);
    tick();
    m.start = 1'b0;
    finish_pass("back_to_back", s2, PASS_CY);

    // Reset during neuron 2's WAIT_ACK, coinciding with the ack.
    slow_en    = 6;
    slow_delay = 2;
    start_pass(-1, 0, -1, 0, s);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m.mac_en && m.w_addr == 6) found = 1;
      else tick();
    end
    if (!found) fail("issue_w6_timeout");
    tick();
    tick();
    rst      = 1'b1;
    ack_mode = 2;
    exp_q.delete();
    tick();
    check("midpass_reset_outputs", out_word(), 0);
    rst = 1'b0;
    tick();
    check("ack_after_reset_ignored", out_word(), 0);
    tick();
    check("still_idle", out_word(), 0);
    ack_mode = 0;
    slow_en  = -1;
    tick();
    start_pass(-1, 0, -1, 0, s);
    finish_pass("after_reset", s, PASS_CY);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
